// File: rtl/npc_redirect.sv
// Fetch-side next-PC unit: sequential increment, stall hold, and EX-stage redirects,
// with a pending-target buffer while the fetch port is busy. Define NPC_PERF_EN for perf counters.
module npc_redirect #(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic [1:0]  npc_sel,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_offset,
    input  logic [31:0] ex_rj,
    input  logic        fetch_ready,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        flush_if,
    output logic        flush_id,
    output logic        target_misalign
`ifdef NPC_PERF_EN
    ,
    output logic [31:0] redirect_cnt,
    output logic [31:0] pend_cnt
`endif
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_PEND = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend_tgt;
    logic        r_pc_valid;
    logic        r_misalign;

    logic [31:0] w_br_tgt;
    logic [31:0] w_jr_tgt;
    logic [31:0] w_tgt_raw;
    logic [31:0] w_tgt;
    logic        w_redir;
    logic        w_in_pend;

    assign w_br_tgt  = ex_pc + ex_offset;
    assign w_jr_tgt  = ex_rj + ex_offset;
    assign w_tgt_raw = (npc_sel == 2'b10) ? w_jr_tgt : w_br_tgt;
    assign w_tgt     = {w_tgt_raw[31:2], 2'b00};
    // Reserved code 01 has bit 1 clear, so it falls through as sequential.
    assign w_redir   = ex_valid & npc_sel[1];
    assign w_in_pend = (r_state == S_PEND);

    // Flushes are combinational so the wrong-path slots die in the redirect cycle itself.
    assign flush_id = rstn & w_redir;
    assign flush_if = rstn & (w_redir | w_in_pend);

    assign pc              = r_pc;
    assign pc_valid        = r_pc_valid;
    assign target_misalign = r_misalign;

    // NOTE: every register here is updated with <= so all of them see the pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= S_RUN;
            r_pc       <= RESET_PC;
            r_pend_tgt <= '0;
            r_pc_valid <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_redir & (w_tgt_raw[1:0] != 2'b00);
            case (r_state)
                S_RUN: begin
                    // A redirect beats stall: the stalled ID instruction is on the wrong path.
                    if (w_redir) begin
                        if (fetch_ready) begin
                            r_pc       <= w_tgt;
                            r_pc_valid <= 1'b1;
                        end else begin
                            r_pend_tgt <= w_tgt;
                            r_state    <= S_PEND;
                            r_pc_valid <= 1'b0;
                        end
                    end else begin
                        r_pc_valid <= 1'b1;
                        if (!stall && fetch_ready) begin
                            r_pc <= r_pc + 32'd4;
                        end
                    end
                end
                S_PEND: begin
                    if (w_redir) begin
                        r_pend_tgt <= w_tgt;
                    end
                    if (fetch_ready) begin
                        r_pc       <= w_redir ? w_tgt : r_pend_tgt;
                        r_state    <= S_RUN;
                        r_pc_valid <= 1'b1;
                    end else begin
                        r_pc_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_RUN;
                    r_pc_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef NPC_PERF_EN
    logic [31:0] r_redirect_cnt;
    logic [31:0] r_pend_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_redirect_cnt <= '0;
            r_pend_cnt     <= '0;
        end else begin
            if (w_redir) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end
            if (w_in_pend) begin
                r_pend_cnt <= r_pend_cnt + 32'd1;
            end
        end
    end

    assign redirect_cnt = r_redirect_cnt;
    assign pend_cnt     = r_pend_cnt;
`endif

endmodule
